regbus_arbiter: RTL and testbench
=================================

// Module: regbus_arbiter
// PURPOSE
//  Shares one user register-file bus (addr/wr/rd/data with wr_ack/rd_ack) between N requesters,
//  e.g. host register port and on-FPGA statistics sequencer. Round-robin grant, one transaction
//  in flight, per-transaction ack timeout. Sits between the requesters and the regfile slave port.
// PARAMETERS
//  N_REQ       2    number of requesters (2..8)
//  ADDR_WIDTH  14   register address width, identical to the slave regfile
//  TIMEOUT     16   cycles in WAIT_ACK before error completion (>=2)
// PORTS
//  clk            in   1            single clock for all logic
//  rst_n_i        in   1            reset, asynchronous assert, active-low
//  m_wr_i         in   N_REQ        write request per requester, level, held until ack/err
//  m_rd_i         in   N_REQ        read request per requester, level, held until ack/err
//  m_addr_i       in   N_REQ*AW     address, slice k = requester k
//  m_wr_data_i    in   N_REQ*32     write data, slice k = requester k
//  m_wr_ack_o     out  N_REQ        1-cycle write completion pulse
//  m_rd_ack_o     out  N_REQ        1-cycle read completion pulse
//  m_err_o        out  N_REQ        1-cycle timeout flag, coincident with the ack pulse
//  m_rd_data_o    out  32           read data, valid only with m_rd_ack_o
//  s_addr_o       out  AW           slave address
//  s_wr_o / s_rd_o out 1            1-cycle slave strobes
//  s_wr_data_o    out  32           slave write data
//  s_wr_ack_i / s_rd_ack_i in 1     slave acks
//  s_rd_data_i    in   32           slave read data, valid with s_rd_ack_i
//  grant_o        out  N_REQ        one-hot current owner, 0 in IDLE
//  busy_o         out  1            high in any state except IDLE
// BEHAVIOUR
//  - Reset: every output 0; state IDLE; timer 0; RR pointer = N_REQ-1 (requester 0 wins first).
//  - FSM IDLE -> ISSUE -> WAIT_ACK -> RESP -> IDLE.
//  - IDLE: req[k] = m_wr_i[k]|m_rd_i[k]; if any, pick first set bit after pointer (wrap);
//    latch addr, wr_data, type (wr if m_wr_i[k], else rd) and grant; go ISSUE.
//  - ISSUE: s_wr_o or s_rd_o high for exactly this cycle; s_addr_o/s_wr_data_o hold latched values
//    from ISSUE through RESP; timer := 0; go WAIT_ACK.
//  - WAIT_ACK: ack of latched type -> capture s_rd_data_i, go RESP. Ack of wrong type ignored.
//    Else timer++; timer == TIMEOUT-1 with no ack -> RESP with err=1.
//  - RESP: pulse m_wr_ack_o[g] or m_rd_ack_o[g]; m_err_o[g] = err; m_rd_data_o = captured data,
//    or 32'hDEAD_BEEF on read timeout; pointer := g; go IDLE.
//  - Latency with 1-cycle slave: request seen at t -> s strobe t+1 -> s ack t+2 -> m ack t+3.
//    Slave latency must be >=1; ack in ISSUE cycle is ignored.
//  - Requester drops its request at the edge it samples ack; so next IDLE cycle sees it low.
//  - Both m_wr_i[k] and m_rd_i[k] high: write served first, read is a later arbitration.
//  - Requests changing after grant have no effect on the in-flight transaction.
//  - Slave acks in IDLE/ISSUE/RESP ignored. A late ack after timeout is dropped.
//  - Async reset mid-transaction: immediate return to reset values, no ack issued.
// STRUCTURE
//  - Package regbus_pkg:
//    - state enum {IDLE, ISSUE, WAIT_ACK, RESP};
//    - ERR_RD_DATA = 32'hDEAD_BEEF;
//    - type localparams.
//  - Sub-module regbus_rr_pick: combinational round-robin picker
//    - inputs req[N_REQ], ptr; outputs onehot grant, valid.
//  - Top holds FSM, latches, timer ($clog2(TIMEOUT) bits), pointer register.
// TESTING
//  1. Reset release; m_wr_i=01, addr 0x10, data 0x1234 -> s_wr_o at t+1 with 0x10/0x1234; m_wr_ack_o=01 at t+3.
//  2. Both request reads continuously -> grants alternate 01,10,01,10; none starved.
//  3. m_rd_i=10, slave returns 0xCAFE_0001 -> m_rd_ack_o=10, m_rd_data_o=0xCAFE_0001, m_err_o=00.
//  4. Slave never acks, TIMEOUT=16 -> m_rd_ack_o and m_err_o pulse 16 cycles after ISSUE,
//     data 0xDEAD_BEEF; late ack ignored.
//  5. m_wr_i=m_rd_i=01 -> write transaction completes first, then read, each with its own ack.
//  6. rst_n_i low during WAIT_ACK -> all outputs 0 at once; after release, requester 0 wins first.

Source files
------------

// File: rtl/regbus_pkg.sv
// Shared types and constants for the register-bus arbiter slice.
package regbus_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_ACK,
      RESP
   } state_t;

   localparam int unsigned DATA_W = 32;
   typedef logic [DATA_W-1:0] word_t;

   localparam word_t ERR_RD_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/regbus_rr_pick.sv
// Combinational round-robin picker: first requester strictly after ptr_i, wrapping.
module regbus_rr_pick
   import regbus_pkg::*;
#(
   parameter int N_REQ = 2,
   parameter int PW    = 1
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [PW-1:0]    ptr_i,
   output logic [N_REQ-1:0] grant_o,
   output logic             valid_o
);

   logic [PW-1:0] idx;

   always_comb begin
      grant_o = '0;
      valid_o = 1'b0;
      idx     = ptr_i;
      for (int i = 0; i < N_REQ; i++) begin
         idx = (idx == PW'(N_REQ - 1)) ? '0 : idx + 1'b1;
         if (!valid_o && req_i[idx]) begin
            grant_o[idx] = 1'b1;
            valid_o      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/regbus_arbiter.sv
// Round-robin arbiter sharing one register-file bus between N_REQ requesters,
// one transaction in flight, with an ack timeout that completes with an error.
module regbus_arbiter
   import regbus_pkg::*;
#(
   parameter int N_REQ      = 2,
   parameter int ADDR_WIDTH = 14,
   parameter int TIMEOUT    = 16
) (
   input  logic                        clk,
   input  logic                        rst_n_i,
   input  logic [N_REQ-1:0]            m_wr_i,
   input  logic [N_REQ-1:0]            m_rd_i,
   input  logic [N_REQ*ADDR_WIDTH-1:0] m_addr_i,
   input  logic [N_REQ*32-1:0]         m_wr_data_i,
   output logic [N_REQ-1:0]            m_wr_ack_o,
   output logic [N_REQ-1:0]            m_rd_ack_o,
   output logic [N_REQ-1:0]            m_err_o,
   output logic [31:0]                 m_rd_data_o,
   output logic [ADDR_WIDTH-1:0]       s_addr_o,
   output logic                        s_wr_o,
   output logic                        s_rd_o,
   output logic [31:0]                 s_wr_data_o,
   input  logic                        s_wr_ack_i,
   input  logic                        s_rd_ack_i,
   input  logic [31:0]                 s_rd_data_i,
   output logic [N_REQ-1:0]            grant_o,
   output logic                        busy_o
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int TW = $clog2(TIMEOUT);

   state_t                  state_q, state_d;
   logic [N_REQ-1:0]        grant_q, grant_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   word_t                   wdata_q, wdata_d;
   word_t                   rdata_q, rdata_d;
   logic                    is_wr_q, is_wr_d;
   logic                    err_q, err_d;
   logic [TW-1:0]           timer_q, timer_d;
   logic [PW-1:0]           ptr_q, ptr_d;

   logic [N_REQ-1:0]        pick_grant;
   logic                    pick_valid;
   logic [ADDR_WIDTH-1:0]   sel_addr;
   word_t                   sel_wdata;
   logic                    sel_wr;
   logic [PW-1:0]           g_idx;
   logic                    ack_match;

   regbus_rr_pick #(
      .N_REQ (N_REQ),
      .PW    (PW)
   ) u_pick (
      .req_i   (m_wr_i | m_rd_i),
      .ptr_i   (ptr_q),
      .grant_o (pick_grant),
      .valid_o (pick_valid)
   );

   // Write wins when a requester raises both strobes; its read is re-arbitrated later.
   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      sel_wr    = 1'b0;
      g_idx     = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (pick_grant[k]) begin
            sel_addr  = m_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
            sel_wdata = m_wr_data_i[k*32 +: 32];
            sel_wr    = m_wr_i[k];
         end
         if (grant_q[k]) begin
            g_idx = PW'(k);
         end
      end
   end

   assign ack_match = is_wr_q ? s_wr_ack_i : s_rd_ack_i;

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      is_wr_d = is_wr_q;
      err_d   = err_q;
      timer_d = timer_q;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               grant_d = pick_grant;
               addr_d  = sel_addr;
               wdata_d = sel_wdata;
               is_wr_d = sel_wr;
               err_d   = 1'b0;
               rdata_d = '0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            timer_d = '0;
            state_d = WAIT_ACK;
         end
         WAIT_ACK: begin
            if (ack_match) begin
               rdata_d = is_wr_q ? '0 : s_rd_data_i;
               state_d = RESP;
            end else if (timer_q == TW'(TIMEOUT - 2)) begin
               // Incremented timer reaches TIMEOUT-1: give up and complete with error.
               err_d   = 1'b1;
               rdata_d = is_wr_q ? '0 : ERR_RD_DATA;
               state_d = RESP;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         RESP: begin
            ptr_d   = g_idx;
            grant_d = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         grant_q <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         is_wr_q <= 1'b0;
         err_q   <= 1'b0;
         timer_q <= '0;
         ptr_q   <= PW'(N_REQ - 1);
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         is_wr_q <= is_wr_d;
         err_q   <= err_d;
         timer_q <= timer_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      busy_o      = (state_q != IDLE);
      grant_o     = busy_o ? grant_q : '0;
      s_addr_o    = busy_o ? addr_q : '0;
      s_wr_data_o = busy_o ? wdata_q : '0;
      s_wr_o      = (state_q == ISSUE) && is_wr_q;
      s_rd_o      = (state_q == ISSUE) && !is_wr_q;
      m_wr_ack_o  = '0;
      m_rd_ack_o  = '0;
      m_err_o     = '0;
      m_rd_data_o = '0;
      if (state_q == RESP) begin
         if (is_wr_q) begin
            m_wr_ack_o = grant_q;
         end else begin
            m_rd_ack_o  = grant_q;
            m_rd_data_o = rdata_q;
         end
         m_err_o = err_q ? grant_q : '0;
      end
   end

endmodule

// File: tb/tb_regbus_arbiter.sv
// Directed bench for regbus_arbiter with a 1-cycle-latency slave model.
module tb_regbus_arbiter;

   localparam int N  = 2;
   localparam int AW = 14;
   localparam int TO = 16;

   logic            clk = 1'b0;
   logic            rst_n_i;
   logic [N-1:0]    m_wr_i, m_rd_i;
   logic [N*AW-1:0] m_addr_i;
   logic [N*32-1:0] m_wr_data_i;
   logic [N-1:0]    m_wr_ack_o, m_rd_ack_o, m_err_o;
   logic [31:0]     m_rd_data_o;
   logic [AW-1:0]   s_addr_o;
   logic            s_wr_o, s_rd_o;
   logic [31:0]     s_wr_data_o;
   logic            s_wr_ack_i, s_rd_ack_i;
   logic [31:0]     s_rd_data_i;
   logic [N-1:0]    grant_o;
   logic            busy_o;

   logic            slave_en;
   logic            late_rd;
   logic [31:0]     slave_rdata;
   int              checks;
   int              failures;

   always #5 clk = ~clk;

   regbus_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
      .clk         (clk),
      .rst_n_i     (rst_n_i),
      .m_wr_i      (m_wr_i),
      .m_rd_i      (m_rd_i),
      .m_addr_i    (m_addr_i),
      .m_wr_data_i (m_wr_data_i),
      .m_wr_ack_o  (m_wr_ack_o),
      .m_rd_ack_o  (m_rd_ack_o),
      .m_err_o     (m_err_o),
      .m_rd_data_o (m_rd_data_o),
      .s_addr_o    (s_addr_o),
      .s_wr_o      (s_wr_o),
      .s_rd_o      (s_rd_o),
      .s_wr_data_o (s_wr_data_o),
      .s_wr_ack_i  (s_wr_ack_i),
      .s_rd_ack_i  (s_rd_ack_i),
      .s_rd_data_i (s_rd_data_i),
      .grant_o     (grant_o),
      .busy_o      (busy_o)
   );

   // Slave: strobe seen in one cycle -> ack during the next cycle.
   initial begin
      bit wr_seen, rd_seen;
      s_wr_ack_i  = 1'b0;
      s_rd_ack_i  = 1'b0;
      s_rd_data_i = '0;
      forever begin
         @(negedge clk);
         wr_seen = slave_en && s_wr_o;
         rd_seen = (slave_en && s_rd_o) || late_rd;
         @(posedge clk);
         #1;
         s_wr_ack_i  = wr_seen;
         s_rd_ack_i  = rd_seen;
         s_rd_data_i = rd_seen ? slave_rdata : 32'h0;
      end
   end

   task automatic wait_ack(input int limit, output int cyc, output bit got);
      got = 1'b0;
      cyc = 0;
      for (int i = 1; i <= limit && !got; i++) begin
         @(negedge clk);
         if ((m_wr_ack_o | m_rd_ack_o) != '0) begin
            got = 1'b1;
            cyc = i;
         end
      end
   endtask

   task automatic do_reset;
      rst_n_i = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n_i = 1'b1;
   endtask

   task automatic test_reset;
      logic [N*3+32+AW+2+32+N+1-1:0] all_out;
      rst_n_i = 1'b0;
      repeat (2) @(negedge clk);
      all_out = {m_wr_ack_o, m_rd_ack_o, m_err_o, m_rd_data_o, s_addr_o, s_wr_o, s_rd_o,
                 s_wr_data_o, grant_o, busy_o};
      checks++;
      if (all_out !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got %h expected 0", all_out);
      end
      rst_n_i = 1'b1;
      @(negedge clk);
      checks++;
      if (busy_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle_busy: got %b expected 0", busy_o);
      end
   endtask

   task automatic test_basic_write;
      @(posedge clk);
      #1;
      m_addr_i    = {14'h0, 14'h0010};
      m_wr_data_i = {32'h0, 32'h0000_1234};
      m_wr_i      = 2'b01;
      @(negedge clk);
      checks++;
      if ({busy_o, s_wr_o} !== 2'b00) begin
         failures++;
         $display("FAIL wr_t0_idle: got busy/s_wr %b expected 00", {busy_o, s_wr_o});
      end
      @(negedge clk);
      checks++;
      if ({s_wr_o, s_rd_o} !== 2'b10) begin
         failures++;
         $display("FAIL wr_t1_strobe: got s_wr/s_rd %b expected 10", {s_wr_o, s_rd_o});
      end
      checks++;
      if (s_addr_o !== 14'h0010 || s_wr_data_o !== 32'h0000_1234) begin
         failures++;
         $display("FAIL wr_t1_bus: got addr %h data %h expected 0010 00001234", s_addr_o, s_wr_data_o);
      end
      checks++;
      if (grant_o !== 2'b01) begin
         failures++;
         $display("FAIL wr_t1_grant: got %b expected 01", grant_o);
      end
      @(negedge clk);
      checks++;
      if ({s_wr_o, m_wr_ack_o} !== 3'b000 || s_addr_o !== 14'h0010) begin
         failures++;
         $display("FAIL wr_t2_wait: got s_wr %b ack %b addr %h expected 0 00 0010", s_wr_o, m_wr_ack_o, s_addr_o);
      end
      @(negedge clk);
      checks++;
      if (m_wr_ack_o !== 2'b01 || m_err_o !== 2'b00 || m_rd_ack_o !== 2'b00) begin
         failures++;
         $display("FAIL wr_t3_ack: got wr_ack %b rd_ack %b err %b expected 01 00 00", m_wr_ack_o, m_rd_ack_o, m_err_o);
      end
      @(posedge clk);
      #1;
      m_wr_i = 2'b00;
      @(negedge clk);
      checks++;
      if ({busy_o, m_wr_ack_o} !== 3'b000) begin
         failures++;
         $display("FAIL wr_after_idle: got busy/ack %b expected 000", {busy_o, m_wr_ack_o});
      end
   endtask

   task automatic test_round_robin;
      logic [N-1:0] exp_g;
      int cyc;
      bit got;
      do_reset();
      slave_rdata = 32'h5A5A_0F0F;
      @(posedge clk);
      #1;
      m_rd_i = 2'b11;
      exp_g  = 2'b01;
      for (int i = 0; i < 4; i++) begin
         wait_ack(20, cyc, got);
         checks++;
         if (!got || m_rd_ack_o !== exp_g) begin
            failures++;
            $display("FAIL rr_grant_%0d: got rd_ack %b (seen %0d) expected %b", i, m_rd_ack_o, got, exp_g);
         end
         checks++;
         if (m_rd_data_o !== 32'h5A5A_0F0F) begin
            failures++;
            $display("FAIL rr_data_%0d: got %h expected 5a5a0f0f", i, m_rd_data_o);
         end
         exp_g = {exp_g[0], exp_g[1]};
      end
      @(posedge clk);
      #1;
      m_rd_i = 2'b00;
   endtask

   task automatic test_read_data;
      int cyc;
      bit got;
      slave_rdata = 32'hCAFE_0001;
      @(posedge clk);
      #1;
      m_rd_i = 2'b10;
      wait_ack(20, cyc, got);
      checks++;
      if (!got || m_rd_ack_o !== 2'b10 || m_wr_ack_o !== 2'b00) begin
         failures++;
         $display("FAIL rd_ack: got rd %b wr %b expected 10 00", m_rd_ack_o, m_wr_ack_o);
      end
      checks++;
      if (m_rd_data_o !== 32'hCAFE_0001 || m_err_o !== 2'b00) begin
         failures++;
         $display("FAIL rd_data: got %h err %b expected cafe0001 00", m_rd_data_o, m_err_o);
      end
      @(posedge clk);
      #1;
      m_rd_i = 2'b00;
   endtask

   task automatic test_timeout;
      int cyc;
      bit got;
      bit seen;
      bit bad;
      slave_en = 1'b0;
      @(posedge clk);
      #1;
      m_rd_i = 2'b01;
      seen   = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         seen = s_rd_o;
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL to_issue: got no s_rd_o expected strobe");
      end
      wait_ack(40, cyc, got);
      checks++;
      if (!got || cyc != TO) begin
         failures++;
         $display("FAIL to_latency: got %0d cycles (seen %0d) expected %0d", cyc, got, TO);
      end
      checks++;
      if (m_rd_ack_o !== 2'b01 || m_err_o !== 2'b01) begin
         failures++;
         $display("FAIL to_flags: got rd_ack %b err %b expected 01 01", m_rd_ack_o, m_err_o);
      end
      checks++;
      if (m_rd_data_o !== 32'hDEAD_BEEF) begin
         failures++;
         $display("FAIL to_data: got %h expected deadbeef", m_rd_data_o);
      end
      @(posedge clk);
      #1;
      m_rd_i  = 2'b00;
      late_rd = 1'b1;
      @(negedge clk);
      #1;
      late_rd = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if ((m_rd_ack_o | m_err_o | m_wr_ack_o) != '0 || busy_o) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         failures++;
         $display("FAIL to_late_ack: got activity after late ack expected none");
      end
      slave_en = 1'b1;
   endtask

   task automatic test_wr_then_rd;
      int cyc;
      bit got;
      slave_rdata = 32'h1111_2222;
      @(posedge clk);
      #1;
      m_addr_i    = {14'h0, 14'h0123};
      m_wr_data_i = {32'h0, 32'h0000_ABCD};
      m_wr_i      = 2'b01;
      m_rd_i      = 2'b01;
      wait_ack(20, cyc, got);
      checks++;
      if (!got || m_wr_ack_o !== 2'b01 || m_rd_ack_o !== 2'b00) begin
         failures++;
         $display("FAIL both_first_wr: got wr %b rd %b expected 01 00", m_wr_ack_o, m_rd_ack_o);
      end
      @(posedge clk);
      #1;
      m_wr_i = 2'b00;
      wait_ack(20, cyc, got);
      checks++;
      if (!got || m_rd_ack_o !== 2'b01 || m_wr_ack_o !== 2'b00) begin
         failures++;
         $display("FAIL both_then_rd: got wr %b rd %b expected 00 01", m_wr_ack_o, m_rd_ack_o);
      end
      checks++;
      if (m_rd_data_o !== 32'h1111_2222) begin
         failures++;
         $display("FAIL both_rd_data: got %h expected 11112222", m_rd_data_o);
      end
      @(posedge clk);
      #1;
      m_rd_i = 2'b00;
   endtask

   task automatic test_async_reset;
      logic [N*3+32+AW+2+32+N+1-1:0] all_out;
      int cyc;
      bit got;
      bit seen;
      slave_en = 1'b0;
      @(posedge clk);
      #1;
      m_addr_i    = {14'h0456, 14'h0};
      m_wr_data_i = {32'h7777_8888, 32'h0};
      m_wr_i      = 2'b10;
      seen        = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         seen = s_wr_o;
      end
      @(negedge clk);
      checks++;
      if (!seen || busy_o !== 1'b1 || grant_o !== 2'b10) begin
         failures++;
         $display("FAIL ar_inflight: got busy %b grant %b expected 1 10", busy_o, grant_o);
      end
      #2;
      rst_n_i = 1'b0;
      #1;
      all_out = {m_wr_ack_o, m_rd_ack_o, m_err_o, m_rd_data_o, s_addr_o, s_wr_o, s_rd_o,
                 s_wr_data_o, grant_o, busy_o};
      checks++;
      if (all_out !== '0) begin
         failures++;
         $display("FAIL ar_outputs: got %h expected 0", all_out);
      end
      m_wr_i = 2'b00;
      repeat (2) @(negedge clk);
      slave_en = 1'b1;
      rst_n_i  = 1'b1;
      @(posedge clk);
      #1;
      m_wr_i      = 2'b11;
      m_addr_i    = {14'h0456, 14'h0055};
      m_wr_data_i = {32'h7777_8888, 32'h0000_5555};
      wait_ack(20, cyc, got);
      checks++;
      if (!got || m_wr_ack_o !== 2'b01) begin
         failures++;
         $display("FAIL ar_first_owner: got wr_ack %b expected 01", m_wr_ack_o);
      end
      @(posedge clk);
      #1;
      m_wr_i = 2'b10;
      wait_ack(20, cyc, got);
      checks++;
      if (!got || m_wr_ack_o !== 2'b10) begin
         failures++;
         $display("FAIL ar_second_owner: got wr_ack %b expected 10", m_wr_ack_o);
      end
      @(posedge clk);
      #1;
      m_wr_i = 2'b00;
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      rst_n_i     = 1'b0;
      m_wr_i      = '0;
      m_rd_i      = '0;
      m_addr_i    = '0;
      m_wr_data_i = '0;
      slave_en    = 1'b1;
      late_rd     = 1'b0;
      slave_rdata = '0;
      test_reset();
      test_basic_write();
      test_round_robin();
      test_read_data();
      test_timeout();
      test_wr_then_rd();
      test_async_reset();
      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
